rr_arbiter: RTL and testbench
=============================

# rr_arbiter

Registered round-robin arbiter with valid/ready handshake, parametrised in requester count. It picks one of `NUM_REQ` request lines per transfer, rotating priority so every active requester is served within `NUM_REQ` transfers. It holds the grant stable under backpressure. It is the sequential successor to the combinational priority encoder in `core_basics` and sits in front of shared resources (bus ports, shared memories) as the standard arbitration primitive.

## Interface
- `NUM_REQ`, 8, number of requesters; must be ≥ 2.
- `IDX_W`, `$clog2(NUM_REQ)`, width of the grant index.

- `clk`  in  1  clock; all state updates on rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `req`  in  `NUM_REQ`  request lines; bit i = requester i.
- `grant_ready`  in  1  downstream accepts the current grant.
- `lock`  in  1  keep the current winner after transfer; present only with `RR_ARB_LOCK_EN`.
- `grant_valid`  out  1  a grant is presented.
- `grant_idx`  out  `IDX_W`  index of the granted requester.
- `grant`  out  `NUM_REQ`  one-hot grant; all-zero when `grant_valid`=0.

## Operation
- State registers:
  - `ptr` (`IDX_W`), the highest-priority index.
  - `grant_valid`.
  - `grant_idx`.
- Transfer: `grant_valid && grant_ready` in a cycle.
- Slot free: `!grant_valid || grant_ready`.
- Effective pointer `eptr`:
  - On transfer: `(grant_idx + 1)`, wrapping `NUM_REQ-1` → 0. Do not use power-of-two masking; non-power-of-two `NUM_REQ` must wrap correctly.
  - Otherwise: `ptr`.
- Arbitration: the winner is the first set bit of `req` scanning `eptr, eptr+1, …, NUM_REQ-1, 0, …, eptr-1`.
- At each edge when the slot is free:
  - `req` non-zero: `grant_valid`←1, `grant_idx`←winner.
  - `req` zero: `grant_valid`←0, `grant_idx` holds.
- At each edge with `grant_valid && !grant_ready`: `grant_idx` and `grant_valid` hold. The grant is sticky even if `req[grant_idx]` drops or other requests change.
- `ptr` ← `eptr` on transfer; otherwise holds.
- `grant` = `grant_valid ? (1 << grant_idx) : 0`, decoded combinationally from registers.
- Fairness: with all requests held high and `grant_ready`=1, each index is granted exactly once per `NUM_REQ` consecutive transfers.

## Timing
- Reset value of every output: `grant_valid`=0, `grant_idx`=0, `grant`=0. Internal `ptr`=0.
- Reset takes effect immediately on `rst_n` falling, including mid-transfer. The first grant after release appears one edge after `req` is sampled non-zero.
- Latency: `req` sampled at edge N → grant visible after edge N (one register stage). There is no combinational path from `req` or `grant_ready` to the outputs.
- Back-to-back: with `grant_ready` held at 1 and requests present, a new grant appears every cycle.
- A requester deasserting `req` while granted and stalled still receives the transfer. Consumers must qualify the transfer with their own state.
- Simultaneous transfer and new requests: arbitration uses `eptr`, so the just-served index has the lowest priority in the same cycle.

## Configuration
- `RR_ARB_LOCK_EN` defined:
  - The `lock` port exists.
  - On a transfer with `lock`=1 and `req[grant_idx]`=1, the next grant is the same `grant_idx` and `ptr` does not advance.
  - With `lock`=1 and `req[grant_idx]`=0, normal round-robin applies.
  - `lock` is ignored when no transfer occurs.
- `RR_ARB_LOCK_EN` undefined: no `lock` port; pure round-robin as above.

## Test plan
Scenarios use `NUM_REQ`=4 unless stated.

1. Reset: assert `rst_n`=0 mid-stream with `req`=4'b1111 → `grant_valid`=0, `grant`=0, `grant_idx`=0 immediately. After release, the first grant is `grant_idx`=0.
2. Full load: `req`=4'b1111, `grant_ready`=1 → `grant_idx` sequence 0,1,2,3,0,1 on consecutive cycles; `grant` 0001,0010,0100,1000.
3. Sparse: `req`=4'b1010, `grant_ready`=1 → `grant_idx` 1,3,1,3; `req`=0 → `grant_valid`=0 the following cycle.
4. Backpressure: `req`=4'b0100, `grant_ready`=0 for 3 cycles → `grant_idx`=2 held. Change `req` to 4'b0001 while stalled → still 2. Then `grant_ready`=1 → transfer, next `grant_idx`=0.
5. Non-power-of-two, `NUM_REQ`=5: `req`=5'b10001, `grant_ready`=1 → `grant_idx` 0,4,0,4. Also `req`=5'b11111 → 0,1,2,3,4,0.
6. Lock (`RR_ARB_LOCK_EN`): `req`=4'b0011, `lock`=1, `grant_ready`=1 → `grant_idx` 0,0,0. Drop `lock` → 1,0,1. Without the macro the same stimulus (minus `lock`) gives 0,1,0.

Source files
------------

// File: rtl/rr_arbiter.sv
// rtl/rr_arbiter.sv - registered round-robin arbiter with valid/ready grant handshake
// Optional feature: define RR_ARB_LOCK_EN to add the lock port (winner re-granted while it keeps requesting).
module rr_arbiter #(
  parameter int NUM_REQ = 8,
  parameter int IDX_W   = $clog2(NUM_REQ)
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [NUM_REQ-1:0] req,
  input  logic               grant_ready,
`ifdef RR_ARB_LOCK_EN
  input  logic               lock,
`endif
  output logic               grant_valid,
  output logic [IDX_W-1:0]   grant_idx,
  output logic [NUM_REQ-1:0] grant
);

  logic [IDX_W-1:0] ptr_q, ptr_d;
  logic             grant_valid_q, grant_valid_d;
  logic [IDX_W-1:0] grant_idx_q, grant_idx_d;

  logic             xfer;
  logic             slot_free;
  logic             lock_hold;
  logic [IDX_W-1:0] eptr;
  logic [IDX_W-1:0] winner;

  assign xfer      = grant_valid_q && grant_ready;
  assign slot_free = !grant_valid_q || grant_ready;

`ifdef RR_ARB_LOCK_EN
  assign lock_hold = xfer && lock && req[grant_idx_q];
`else
  assign lock_hold = 1'b0;
`endif

  // Explicit wrap so non-power-of-two NUM_REQ rolls over at NUM_REQ-1.
  always_comb begin
    eptr = ptr_q;
    if (xfer) begin
      if (grant_idx_q == IDX_W'(NUM_REQ - 1)) eptr = '0;
      else                                    eptr = grant_idx_q + 1'b1;
    end
  end

  // Scan from the far end back toward eptr so the nearest requester wins.
  always_comb begin
    int               s;
    logic [IDX_W-1:0] cand;
    winner = eptr;
    s      = 0;
    cand   = '0;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      s = int'(eptr) + k;
      if (s >= NUM_REQ) s = s - NUM_REQ;
      cand = IDX_W'(s);
      if (req[cand]) winner = cand;
    end
    if (lock_hold) winner = grant_idx_q;
  end

  always_comb begin
    grant_valid_d = grant_valid_q;
    grant_idx_d   = grant_idx_q;
    ptr_d         = ptr_q;
    if (slot_free) begin
      if (|req) begin
        grant_valid_d = 1'b1;
        grant_idx_d   = winner;
      end else begin
        grant_valid_d = 1'b0;
      end
    end
    if (xfer && !lock_hold) ptr_d = eptr;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr_q         <= '0;
      grant_valid_q <= 1'b0;
      grant_idx_q   <= '0;
    end else begin
      ptr_q         <= ptr_d;
      grant_valid_q <= grant_valid_d;
      grant_idx_q   <= grant_idx_d;
    end
  end

  always_comb begin
    grant = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      grant[i] = grant_valid_q && (grant_idx_q == IDX_W'(i));
    end
  end

  assign grant_valid = grant_valid_q;
  assign grant_idx   = grant_idx_q;

endmodule

// File: tb/tb_rr_arbiter.sv
// tb/tb_rr_arbiter.sv - directed self-checking bench for rr_arbiter (4- and 5-requester instances)
module tb_rr_arbiter;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [3:0] req4;
  logic       ready4;
  logic       lock;
  logic       gv4;
  logic [1:0] idx4;
  logic [3:0] grant4;
  logic [4:0] req5;
  logic       ready5;
  logic       gv5;
  logic [2:0] idx5;
  logic [4:0] grant5;

  int n_assert = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  rr_arbiter #(.NUM_REQ(4)) u4 (
    .clk         (clk),
    .rst_n       (rst_n),
    .req         (req4),
    .grant_ready (ready4),
`ifdef RR_ARB_LOCK_EN
    .lock        (lock),
`endif
    .grant_valid (gv4),
    .grant_idx   (idx4),
    .grant       (grant4)
  );

  rr_arbiter #(.NUM_REQ(5)) u5 (
    .clk         (clk),
    .rst_n       (rst_n),
    .req         (req5),
    .grant_ready (ready5),
`ifdef RR_ARB_LOCK_EN
    .lock        (lock),
`endif
    .grant_valid (gv5),
    .grant_idx   (idx5),
    .grant       (grant5)
  );

  task automatic chk(input string tag, input int obs, input int exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst_n = 1'b0; req4 = '0; ready4 = 1'b0; lock = 1'b0; req5 = '0; ready5 = 1'b0;
    step(); step();
    chk("rst_gv", gv4, 0);
    chk("rst_idx", idx4, 0);
    chk("rst_grant", grant4, 0);
    rst_n = 1'b1;

    // full load: 0,1,2,3,0,1
    req4 = 4'b1111; ready4 = 1'b1;
    step(); chk("full_idx0", idx4, 0); chk("full_g0", grant4, 4'b0001); chk("full_gv", gv4, 1);
    step(); chk("full_idx1", idx4, 1); chk("full_g1", grant4, 4'b0010);
    step(); chk("full_idx2", idx4, 2); chk("full_g2", grant4, 4'b0100);
    step(); chk("full_idx3", idx4, 3); chk("full_g3", grant4, 4'b1000);
    step(); chk("full_idx4", idx4, 0);
    step(); chk("full_idx5", idx4, 1);

    // asynchronous reset mid-stream
    #2 rst_n = 1'b0;
    #1;
    chk("async_rst_gv", gv4, 0);
    chk("async_rst_idx", idx4, 0);
    chk("async_rst_grant", grant4, 0);
    #1 rst_n = 1'b1;
    step(); chk("post_rst_idx", idx4, 0); chk("post_rst_gv", gv4, 1);

    // sparse 1010: 1,3,1,3 then idle
    req4 = 4'b1010;
    step(); chk("sparse0", idx4, 1);
    step(); chk("sparse1", idx4, 3);
    step(); chk("sparse2", idx4, 1);
    step(); chk("sparse3", idx4, 3);
    req4 = 4'b0000;
    step(); chk("idle_gv", gv4, 0); chk("idle_grant", grant4, 0); chk("idle_idx_hold", idx4, 3);

    // backpressure holds grant even as req changes
    req4 = 4'b0100; ready4 = 1'b0;
    step(); chk("bp_first", idx4, 2);
    step(); chk("bp_hold1", idx4, 2);
    step(); chk("bp_hold2", idx4, 2);
    req4 = 4'b0001;
    step(); chk("bp_sticky", idx4, 2); chk("bp_sticky_gv", gv4, 1); chk("bp_sticky_g", grant4, 4'b0100);
    ready4 = 1'b1;
    step(); chk("bp_release", idx4, 0);
    req4 = 4'b0000;
    step(); chk("bp_idle", gv4, 0);

    // lock behaviour from a clean pointer
    #2 rst_n = 1'b0;
    #1 rst_n = 1'b1;
    req4 = 4'b0011; ready4 = 1'b1;
`ifdef RR_ARB_LOCK_EN
    lock = 1'b1;
    step(); chk("lock0", idx4, 0);
    step(); chk("lock1", idx4, 0);
    step(); chk("lock2", idx4, 0);
    lock = 1'b0;
    step(); chk("unlock0", idx4, 1);
    step(); chk("unlock1", idx4, 0);
    step(); chk("unlock2", idx4, 1);
`else
    step(); chk("nolock0", idx4, 0);
    step(); chk("nolock1", idx4, 1);
    step(); chk("nolock2", idx4, 0);
`endif
    req4 = 4'b0000;

    // non-power-of-two wrap with 5 requesters
    req5 = 5'b10001; ready5 = 1'b1;
    step(); chk("np2_a0", idx5, 0);
    step(); chk("np2_a1", idx5, 4); chk("np2_g4", grant5, 5'b10000);
    step(); chk("np2_a2", idx5, 0);
    step(); chk("np2_a3", idx5, 4);
    req5 = 5'b11111;
    step(); chk("np2_b0", idx5, 0);
    step(); chk("np2_b1", idx5, 1);
    step(); chk("np2_b2", idx5, 2);
    step(); chk("np2_b3", idx5, 3);
    step(); chk("np2_b4", idx5, 4);
    step(); chk("np2_b5", idx5, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
